rcc_div_switch_ctrl: RTL and testbench
======================================

RCC_DIV_SWITCH_CTRL -- requirements
Module: rcc_div_switch_ctrl

Interface
REQ-001 Parameter OFF_CYC, default 4: cycles the downstream clock gate stays closed before div_sel changes (legal range 1..2047).
REQ-002 Parameter SETTLE_CYC, default 1040: cycles after div_sel changes before the gate reopens; covers the ratio register stage plus one full 512-ratio output period (legal range 1..2047).
REQ-003 i_clk  input  1  sole clock; all logic is on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 testmode  input  1  bypass sequencing when high.
REQ-006 req_valid  input  1  new divider selection requested.
REQ-007 req_sel  input  4  requested selection, in the divider's div_sel encoding.
REQ-008 req_ready  output  1  controller can accept a request.
REQ-009 div_sel  output  4  registered selection driven to the clock divider.
REQ-010 gate_en  output  1  registered enable for the downstream glitch-free clock gate.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 done  output  1  one-cycle pulse when a request completes.

Function
REQ-013 A handshake shall occur on a cycle with req_valid=1 and req_ready=1; req_sel and testmode shall be captured only on that cycle.
REQ-014 req_ready shall be 1 only in IDLE; req_valid while busy shall be ignored and shall not be queued.
REQ-015 Normalization: any req_sel with bit3=0 shall be stored as 4'b0000 (div 1); 4'b1000..4'b1111 shall be stored unchanged.
REQ-016 States: IDLE, GATE_OFF, SWITCH, GATE_ON.
REQ-017 If the normalized sel equals the current div_sel, IDLE shall stay IDLE, and done shall pulse on the next cycle; gate_en and div_sel shall not change.
REQ-018 If the captured testmode=1 and the sel differs, div_sel shall update on the next cycle, gate_en shall stay 1, done shall pulse on that same cycle, and the state shall remain IDLE.
REQ-019 Otherwise: IDLE->GATE_OFF; gate_en=0 from the next cycle; the 11-bit counter loads OFF_CYC-1.
REQ-020 In GATE_OFF, the state shall decrement to 0, then go to SWITCH; div_sel shall take the captured sel on SWITCH entry, and the counter shall load SETTLE_CYC-1.
REQ-021 In SWITCH, the state shall decrement to 0, then go to GATE_ON; gate_en=1 on GATE_ON entry.
REQ-022 GATE_ON shall last exactly 1 cycle with done=1, then return to IDLE with req_ready=1.
REQ-023 Total latency for a non-bypassed switch, from the handshake edge to the done pulse, shall be OFF_CYC+SETTLE_CYC+1 cycles.
REQ-024 gate_en shall be 0 throughout every cycle in which div_sel differs from its pre-request value, up to GATE_ON.
REQ-025 A testmode change after the handshake shall not affect an in-flight sequence.
REQ-026 The counter shall never wrap, because parameters are limited to 2047; an elaboration-time check shall reject 0 or values above 2047.

Reset
REQ-027 When rst=1 at a clock edge, the following shall hold on the next cycle: state=IDLE, div_sel=4'b0000, gate_en=1, req_ready=1, busy=0, done=0, counter=0.
REQ-028 Reset asserted mid-sequence shall abort it with no done pulse; the captured request shall be discarded.

Structure
REQ-029 Shared package rcc_div_pkg shall hold the state enum, the div_sel encoding constants (SEL_DIV1 through SEL_DIV512), and the normalization function.
REQ-030 One sub-module, rcc_div_wait_cnt (11-bit load/decrement counter with zero flag), shall be instantiated.
REQ-031 All outputs shall be registered; there shall be no combinational path from req_valid to req_ready.

Verification
REQ-032 After reset, req_sel=4'b1010 with testmode=0 -> gate_en low cycles 1..1044, div_sel=4'b1010 from cycle 5, done at cycle 1045.
REQ-033 In IDLE with div_sel=4'b1010, req_sel=4'b1010 -> done at cycle 1, gate_en stays 1, busy stays 0.
REQ-034 req_sel=4'b0110 with testmode=1 -> div_sel=4'b0000 if it differs (else no change), done at cycle 1, gate_en never drops.
REQ-035 req_valid held high during a sequence with a different sel -> ignored; exactly one done; final div_sel equals the first request.
REQ-036 rst pulse at cycle 10 of a switch -> next cycle shows div_sel=4'b0000, gate_en=1, req_ready=1, and no done pulse.

Source files
------------

// File: rtl/rcc_div_pkg.sv
// Shared types for the RCC divider switch controller: FSM states, the
// divider select encoding and the request normalization rule.
package rcc_div_pkg;

  localparam int CNT_W   = 11;
  localparam int CNT_MAX = 2047;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GATE_OFF = 2'd1,
    ST_SWITCH   = 2'd2,
    ST_GATE_ON  = 2'd3
  } state_t;

  // Divider select codes; every code with bit3 clear means divide-by-1.
  typedef enum logic [3:0] {
    SEL_DIV1   = 4'b0000,
    SEL_DIV2   = 4'b1000,
    SEL_DIV4   = 4'b1001,
    SEL_DIV8   = 4'b1010,
    SEL_DIV16  = 4'b1011,
    SEL_DIV64  = 4'b1100,
    SEL_DIV128 = 4'b1101,
    SEL_DIV256 = 4'b1110,
    SEL_DIV512 = 4'b1111
  } div_sel_e;

  function automatic logic [3:0] normalize_sel(input logic [3:0] sel);
    return sel[3] ? sel : SEL_DIV1;
  endfunction

  function automatic logic cyc_param_ok(input int value);
    return (value >= 1) && (value <= CNT_MAX);
  endfunction

endpackage

// File: rtl/rcc_div_switch_ctrl_if.sv
// Request handshake and divider/gate control bundle between a requester
// (master) and the switch controller (slave).
interface rcc_div_switch_ctrl_if;

  logic       testmode;
  logic       req_valid;
  logic [3:0] req_sel;
  logic       req_ready;
  logic [3:0] div_sel;
  logic       gate_en;
  logic       busy;
  logic       done;

  modport master (
    output testmode,
    output req_valid,
    output req_sel,
    input  req_ready,
    input  div_sel,
    input  gate_en,
    input  busy,
    input  done
  );

  modport slave (
    input  testmode,
    input  req_valid,
    input  req_sel,
    output req_ready,
    output div_sel,
    output gate_en,
    output busy,
    output done
  );

endinterface

// File: rtl/rcc_div_wait_cnt.sv
// 11-bit load/decrement wait counter; holds at zero rather than wrapping.
module rcc_div_wait_cnt
  import rcc_div_pkg::*;
(
  input  logic             i_clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_val;
    end else if (dec && (count_reg != '0)) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/rcc_div_switch_ctrl.sv
// Sequences a clock divider ratio change: close the downstream gate, wait,
// switch div_sel, wait for the new ratio to settle, reopen the gate.
module rcc_div_switch_ctrl
  import rcc_div_pkg::*;
#(
  parameter int OFF_CYC    = 4,
  parameter int SETTLE_CYC = 1040
) (
  input  logic                  i_clk,
  input  logic                  rst,
  rcc_div_switch_ctrl_if.slave  bus
);

  if (!cyc_param_ok(OFF_CYC)) begin : g_bad_off_cyc
    $error("rcc_div_switch_ctrl: OFF_CYC must be in 1..2047");
  end
  if (!cyc_param_ok(SETTLE_CYC)) begin : g_bad_settle_cyc
    $error("rcc_div_switch_ctrl: SETTLE_CYC must be in 1..2047");
  end

  localparam logic [CNT_W-1:0] OFF_LOAD    = CNT_W'(OFF_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

  state_t     state_reg,   state_next;
  logic [3:0] div_sel_reg, div_sel_next;
  logic [3:0] sel_cap_reg, sel_cap_next;
  logic       gate_en_reg, gate_en_next;
  logic       done_reg,    done_next;
  logic       ready_reg;
  logic       busy_reg;

  logic             handshake;
  logic [3:0]       sel_norm;
  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;

  assign handshake = bus.req_valid && ready_reg;
  assign sel_norm  = normalize_sel(bus.req_sel);

  rcc_div_wait_cnt u_wait_cnt (
    .i_clk    (i_clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_next   = state_reg;
    div_sel_next = div_sel_reg;
    sel_cap_next = sel_cap_reg;
    gate_en_next = gate_en_reg;
    done_next    = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = '0;

    case (state_reg)
      ST_IDLE: begin
        if (handshake) begin
          if (sel_norm == div_sel_reg) begin
            done_next = 1'b1;
          end else if (bus.testmode) begin
            // Bypass: switch in place with the gate left open.
            div_sel_next = sel_norm;
            done_next    = 1'b1;
          end else begin
            state_next   = ST_GATE_OFF;
            gate_en_next = 1'b0;
            sel_cap_next = sel_norm;
            cnt_load     = 1'b1;
            cnt_load_val = OFF_LOAD;
          end
        end
      end

      ST_GATE_OFF: begin
        if (cnt_zero) begin
          state_next   = ST_SWITCH;
          div_sel_next = sel_cap_reg;
          cnt_load     = 1'b1;
          cnt_load_val = SETTLE_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      ST_SWITCH: begin
        if (cnt_zero) begin
          state_next   = ST_GATE_ON;
          gate_en_next = 1'b1;
          done_next    = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      ST_GATE_ON: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ready/busy are registered from the next state so req_valid never
  // reaches req_ready combinationally.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      div_sel_reg <= SEL_DIV1;
      sel_cap_reg <= SEL_DIV1;
      gate_en_reg <= 1'b1;
      done_reg    <= 1'b0;
      ready_reg   <= 1'b1;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      div_sel_reg <= div_sel_next;
      sel_cap_reg <= sel_cap_next;
      gate_en_reg <= gate_en_next;
      done_reg    <= done_next;
      ready_reg   <= (state_next == ST_IDLE);
      busy_reg    <= (state_next != ST_IDLE);
    end
  end

  assign bus.req_ready = ready_reg;
  assign bus.div_sel   = div_sel_reg;
  assign bus.gate_en   = gate_en_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;

endmodule

// File: tb/tb_rcc_div_switch_ctrl.sv
// Self-checking bench for rcc_div_switch_ctrl: directed scenarios plus
// randomized requests against a cycle-indexed behavioural model.
module tb_rcc_div_switch_ctrl;

  localparam int OFF    = 4;
  localparam int SETTLE = 1040;
  localparam int LAT    = OFF + SETTLE + 1;
  localparam int MAXC   = LAT + 4;

  logic i_clk = 1'b0;
  logic rst   = 1'b1;
  int   errors = 0;
  int   checks = 0;

  rcc_div_switch_ctrl_if bus();

  rcc_div_switch_ctrl #(.OFF_CYC(OFF), .SETTLE_CYC(SETTLE)) dut (
    .i_clk (i_clk),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  logic [3:0] obs_div   [0:MAXC];
  logic       obs_gate  [0:MAXC];
  logic       obs_done  [0:MAXC];
  logic       obs_busy  [0:MAXC];
  logic       obs_ready [0:MAXC];
  logic [3:0] exp_div   [0:MAXC];
  logic       exp_gate  [0:MAXC];
  logic       exp_done  [0:MAXC];
  logic       exp_busy  [0:MAXC];
  logic       exp_ready [0:MAXC];
  logic [3:0] model_sel;

  function automatic logic [3:0] ref_norm(input logic [3:0] s);
    if (s >= 4'd8) return s;
    return 4'd0;
  endfunction

  // Expected waveform of one request, indexed by cycles after the handshake.
  task automatic build_expect(input logic [3:0] sel, input logic tm, output int lat);
    logic [3:0] n;
    logic [3:0] p;
    bit slow;
    n = ref_norm(sel);
    p = model_sel;
    slow = (n != p) && !tm;
    lat = slow ? LAT : 1;
    for (int k = 1; k <= MAXC; k++) begin
      exp_done[k]  = (k == lat);
      exp_div[k]   = (n == p) ? p : (tm ? n : ((k > OFF) ? n : p));
      exp_gate[k]  = !(slow && (k <= OFF + SETTLE));
      exp_busy[k]  = slow && (k <= LAT);
      exp_ready[k] = !exp_busy[k];
    end
    model_sel = n;
  endtask

  task automatic record(input int k);
    obs_div[k]   = bus.div_sel;
    obs_gate[k]  = bus.gate_en;
    obs_done[k]  = bus.done;
    obs_busy[k]  = bus.busy;
    obs_ready[k] = bus.req_ready;
  endtask

  task automatic do_req(input logic [3:0] sel, input logic tm, input int ncyc,
                        input bit hold, input logic [3:0] sel2);
    @(negedge i_clk);
    record(0);
    bus.req_valid = 1'b1;
    bus.req_sel   = sel;
    bus.testmode  = tm;
    @(negedge i_clk);
    for (int k = 1; k <= ncyc; k++) begin
      record(k);
      if (k == 1) begin
        bus.testmode = ~tm;
        if (hold) bus.req_sel = sel2;
        else bus.req_valid = 1'b0;
      end
      if (hold && (k == LAT)) bus.req_valid = 1'b0;
      @(negedge i_clk);
    end
    bus.req_valid = 1'b0;
    bus.testmode  = 1'b0;
    $display("req sel=%b testmode=%0d hold=%0d observed_cycles=%0d", sel, tm, hold, ncyc);
  endtask

  task automatic count_mism(input int ncyc, output int m_div, output int m_gate,
                            output int m_done, output int m_busy, output int m_ready,
                            output int first_bad);
    m_div = 0; m_gate = 0; m_done = 0; m_busy = 0; m_ready = 0; first_bad = -1;
    for (int k = 1; k <= ncyc; k++) begin
      bit bad;
      bad = 1'b0;
      if (obs_div[k]   !== exp_div[k])   begin m_div++;   bad = 1'b1; end
      if (obs_gate[k]  !== exp_gate[k])  begin m_gate++;  bad = 1'b1; end
      if (obs_done[k]  !== exp_done[k])  begin m_done++;  bad = 1'b1; end
      if (obs_busy[k]  !== exp_busy[k])  begin m_busy++;  bad = 1'b1; end
      if (obs_ready[k] !== exp_ready[k]) begin m_ready++; bad = 1'b1; end
      if (bad && first_bad < 0) first_bad = k;
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0;
    bus.req_sel   = 4'd0;
    bus.testmode  = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge i_clk);
    rst = 1'b0;
    model_sel = 4'd0;
    checks++; if (bus.div_sel !== 4'b0000) begin errors++; $display("FAIL reset_div_sel: got %b expected 0000", bus.div_sel); end
    checks++; if (bus.gate_en !== 1'b1) begin errors++; $display("FAIL reset_gate_en: got %b expected 1", bus.gate_en); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
  endtask

  task automatic test_normal_switch();
    int lat, md, mg, mdn, mb, mr, fb;
    int first_chg, done_cyc, done_cnt, gate_low, unsafe;
    build_expect(4'b1010, 1'b0, lat);
    do_req(4'b1010, 1'b0, MAXC, 1'b0, 4'd0);
    first_chg = -1; done_cyc = -1; done_cnt = 0; gate_low = 0; unsafe = 0;
    for (int k = 1; k <= MAXC; k++) begin
      if (first_chg < 0 && obs_div[k] !== 4'b0000) first_chg = k;
      if (obs_done[k] === 1'b1) begin done_cnt++; if (done_cyc < 0) done_cyc = k; end
      if (obs_gate[k] === 1'b0) gate_low++;
      if (k < 1045 && obs_div[k] !== 4'b0000 && obs_gate[k] !== 1'b0) unsafe++;
    end
    checks++; if (obs_ready[0] !== 1'b1) begin errors++; $display("FAIL normal_ready_before: got %b expected 1", obs_ready[0]); end
    checks++; if (done_cyc != 1045) begin errors++; $display("FAIL normal_done_cycle: got %0d expected 1045", done_cyc); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL normal_done_count: got %0d expected 1", done_cnt); end
    checks++; if (first_chg != 5) begin errors++; $display("FAIL normal_div_change_cycle: got %0d expected 5", first_chg); end
    checks++; if (gate_low != 1044) begin errors++; $display("FAIL normal_gate_low_cycles: got %0d expected 1044", gate_low); end
    checks++; if (unsafe != 0) begin errors++; $display("FAIL normal_gate_open_while_switched: got %0d cycles expected 0", unsafe); end
    count_mism(MAXC, md, mg, mdn, mb, mr, fb);
    checks++; if (md + mg + mdn + mb + mr != 0)
      begin errors++; $display("FAIL normal_waveform: got %0d mismatches (first at cycle %0d) expected 0", md + mg + mdn + mb + mr, fb); end
  endtask

  task automatic test_same_sel();
    int lat, md, mg, mdn, mb, mr, fb;
    build_expect(4'b1010, 1'b0, lat);
    do_req(4'b1010, 1'b0, 6, 1'b0, 4'd0);
    count_mism(6, md, mg, mdn, mb, mr, fb);
    checks++; if (obs_done[1] !== 1'b1) begin errors++; $display("FAIL same_done_cycle1: got %b expected 1", obs_done[1]); end
    checks++; if (mg != 0) begin errors++; $display("FAIL same_gate_stays_high: got %0d bad cycles expected 0", mg); end
    checks++; if (mb != 0) begin errors++; $display("FAIL same_busy_stays_low: got %0d bad cycles expected 0", mb); end
    checks++; if (md + mdn + mr != 0) begin errors++; $display("FAIL same_waveform: got %0d mismatches (first at cycle %0d) expected 0", md + mdn + mr, fb); end
  endtask

  task automatic test_testmode();
    int lat, md, mg, mdn, mb, mr, fb;
    build_expect(4'b0110, 1'b1, lat);
    do_req(4'b0110, 1'b1, 6, 1'b0, 4'd0);
    count_mism(6, md, mg, mdn, mb, mr, fb);
    checks++; if (obs_div[1] !== 4'b0000) begin errors++; $display("FAIL tm_div_sel_cycle1: got %b expected 0000", obs_div[1]); end
    checks++; if (obs_done[1] !== 1'b1) begin errors++; $display("FAIL tm_done_cycle1: got %b expected 1", obs_done[1]); end
    checks++; if (mg != 0) begin errors++; $display("FAIL tm_gate_never_drops: got %0d bad cycles expected 0", mg); end
    checks++; if (md + mdn + mb + mr != 0) begin errors++; $display("FAIL tm_waveform: got %0d mismatches (first at cycle %0d) expected 0", md + mdn + mb + mr, fb); end
    build_expect(4'b0110, 1'b1, lat);
    do_req(4'b0110, 1'b1, 6, 1'b0, 4'd0);
    count_mism(6, md, mg, mdn, mb, mr, fb);
    checks++; if (md + mg + mdn + mb + mr != 0) begin errors++; $display("FAIL tm_same_waveform: got %0d mismatches (first at cycle %0d) expected 0", md + mg + mdn + mb + mr, fb); end
  endtask

  task automatic test_hold_valid();
    int lat, md, mg, mdn, mb, mr, fb, done_cnt;
    build_expect(4'b1111, 1'b0, lat);
    do_req(4'b1111, 1'b0, MAXC, 1'b1, 4'b1001);
    done_cnt = 0;
    for (int k = 1; k <= MAXC; k++) if (obs_done[k] === 1'b1) done_cnt++;
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL hold_done_count: got %0d expected 1", done_cnt); end
    checks++; if (obs_div[MAXC] !== 4'b1111) begin errors++; $display("FAIL hold_final_div_sel: got %b expected 1111", obs_div[MAXC]); end
    count_mism(MAXC, md, mg, mdn, mb, mr, fb);
    checks++; if (md + mg + mdn + mb + mr != 0) begin errors++; $display("FAIL hold_waveform: got %0d mismatches (first at cycle %0d) expected 0", md + mg + mdn + mb + mr, fb); end
  endtask

  task automatic test_reset_mid();
    int done_cnt, div_bad;
    @(negedge i_clk);
    bus.req_valid = 1'b1;
    bus.req_sel   = 4'b1010;
    bus.testmode  = 1'b0;
    @(negedge i_clk);
    bus.req_valid = 1'b0;
    repeat (9) @(negedge i_clk);
    checks++; if (bus.gate_en !== 1'b0) begin errors++; $display("FAIL midrst_gate_closed_before: got %b expected 0", bus.gate_en); end
    rst = 1'b1;
    @(negedge i_clk);
    rst = 1'b0;
    model_sel = 4'd0;
    checks++; if (bus.div_sel !== 4'b0000) begin errors++; $display("FAIL midrst_div_sel: got %b expected 0000", bus.div_sel); end
    checks++; if (bus.gate_en !== 1'b1) begin errors++; $display("FAIL midrst_gate_en: got %b expected 1", bus.gate_en); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL midrst_req_ready: got %b expected 1", bus.req_ready); end
    done_cnt = 0; div_bad = 0;
    for (int k = 0; k < LAT + 10; k++) begin
      if (bus.done === 1'b1) done_cnt++;
      if (bus.div_sel !== 4'b0000 || bus.gate_en !== 1'b1) div_bad++;
      @(negedge i_clk);
    end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", done_cnt); end
    checks++; if (div_bad != 0) begin errors++; $display("FAIL midrst_request_discarded: got %0d bad cycles expected 0", div_bad); end
    $display("req sel=1010 testmode=0 aborted by reset at cycle 10");
  endtask

  task automatic test_random();
    int lat, ncyc, md, mg, mdn, mb, mr, fb;
    logic [3:0] sel;
    logic tm;
    for (int i = 0; i < 12; i++) begin
      sel = 4'($urandom_range(0, 15));
      tm  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) sel = model_sel;
      build_expect(sel, tm, lat);
      ncyc = (lat == 1) ? 4 : LAT + 2;
      do_req(sel, tm, ncyc, 1'b0, 4'd0);
      count_mism(ncyc, md, mg, mdn, mb, mr, fb);
      checks++; if (obs_ready[0] !== 1'b1) begin errors++; $display("FAIL rand%0d_ready_before: got %b expected 1", i, obs_ready[0]); end
      checks++; if (md != 0) begin errors++; $display("FAIL rand%0d_div_sel: got %0d bad cycles (first %0d) expected 0", i, md, fb); end
      checks++; if (mg != 0) begin errors++; $display("FAIL rand%0d_gate_en: got %0d bad cycles (first %0d) expected 0", i, mg, fb); end
      checks++; if (mdn != 0) begin errors++; $display("FAIL rand%0d_done: got %0d bad cycles (first %0d) expected 0", i, mdn, fb); end
      checks++; if (mb + mr != 0) begin errors++; $display("FAIL rand%0d_busy_ready: got %0d bad cycles (first %0d) expected 0", i, mb + mr, fb); end
    end
  endtask

  initial begin
    test_reset();
    test_normal_switch();
    test_same_sel();
    test_testmode();
    test_hold_valid();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
